// File: rtl/bcd_tens_tracker.sv
// bcd_tens_tracker
// Watches the units digit of a BCD up/down counter and keeps a tens digit.
// A 9->0 sample is a carry and a 0->9 sample is a borrow. Illegal codes,
// non-adjacent steps and tens wraps raise sticky flags. A snapshot
// handshake gives readers a coherent {tens,units} pair.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_PRIME | no previous sample yet; the next edge only loads prev
// ST_TRACK | prev holds the last sample; wrap and step decisions active

module bcd_tens_tracker #(
  parameter int TENS_MAX   = 9,
  parameter int CHECK_STEP = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       clr_err,
  input  logic       snap_req,
  input  logic       snap_ack,
  output logic [3:0] tens,
  output logic       carry_p,
  output logic       borrow_p,
  output logic       ovf,
  output logic       unf,
  output logic       code_err,
  output logic       step_err,
  output logic       snap_valid,
  output logic [3:0] snap_tens,
  output logic [3:0] snap_units
);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [3:0] TENS_TOP = 4'(TENS_MAX);
  localparam logic       STEP_EN  = (CHECK_STEP != 0);

  state_t     state_q;
  state_t     state_d;

  logic [3:0] units;
  logic       units_legal;

  logic [3:0] prev_q;
  logic       prev_legal_q;
  logic [3:0] prev_inc;
  logic [3:0] prev_dec;

  logic       carry_d;
  logic       borrow_d;
  logic       code_bad;
  logic       step_bad;

  logic [3:0] tens_d;
  logic       ovf_set;
  logic       unf_set;

  logic       snap_capture;
  logic       snap_valid_d;

  assign units       = {A, B, C, D};
  assign units_legal = (units <= 4'd9);

  // Neighbours of the previous digit, modulo 10.
  always_comb begin
    prev_inc = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;
    prev_dec = (prev_q == 4'd0) ? 4'd9 : prev_q - 4'd1;
  end

  // State register: leaves PRIME on the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the per-sample wrap, code and step decisions.
  always_comb begin
    state_d  = state_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    step_bad = 1'b0;
    code_bad = !units_legal;
    case (state_q)
      ST_PRIME: begin
        state_d = ST_TRACK;
      end
      ST_TRACK: begin
        // Either side illegal: no wrap and no step judgement this cycle.
        if (units_legal && prev_legal_q) begin
          carry_d  = (prev_q == 4'd9) && (units == 4'd0);
          borrow_d = (prev_q == 4'd0) && (units == 4'd9);
          step_bad = STEP_EN &&
                     !((units == prev_q) || (units == prev_inc) || (units == prev_dec));
        end
      end
      default: begin
        state_d = ST_PRIME;
      end
    endcase
  end

  // Tens digit next value, wrapping between TENS_MAX and 0.
  always_comb begin
    tens_d  = tens;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (carry_d) begin
      if (tens >= TENS_TOP) begin
        tens_d  = 4'd0;
        ovf_set = 1'b1;
      end else begin
        tens_d = tens + 4'd1;
      end
    end else if (borrow_d) begin
      if (tens == 4'd0) begin
        tens_d  = TENS_TOP;
        unf_set = 1'b1;
      end else begin
        tens_d = tens - 4'd1;
      end
    end
  end

  // Previous-sample history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q       <= 4'd0;
      prev_legal_q <= 1'b0;
    end else begin
      prev_q       <= units;
      prev_legal_q <= units_legal;
    end
  end

  // Tens register and one-cycle wrap pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tens     <= 4'd0;
      carry_p  <= 1'b0;
      borrow_p <= 1'b0;
    end else begin
      tens     <= tens_d;
      carry_p  <= carry_d;
      borrow_p <= borrow_d;
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
      code_err <= 1'b0;
      step_err <= 1'b0;
    end else begin
      ovf      <= ovf_set  | (ovf      & !clr_err);
      unf      <= unf_set  | (unf      & !clr_err);
      code_err <= code_bad | (code_err & !clr_err);
      step_err <= step_bad | (step_err & !clr_err);
    end
  end

  // Capture when empty, or when the reader acks in the same cycle.
  always_comb begin
    snap_capture = snap_req && (!snap_valid || snap_ack);
    snap_valid_d = snap_valid;
    if (snap_capture) begin
      snap_valid_d = 1'b1;
    end else if (snap_ack) begin
      snap_valid_d = 1'b0;
    end
  end

  // Snapshot registers take the tens value after this edge's update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_valid <= 1'b0;
      snap_tens  <= 4'd0;
      snap_units <= 4'd0;
    end else begin
      snap_valid <= snap_valid_d;
      if (snap_capture) begin
        snap_tens  <= tens_d;
        snap_units <= units;
      end
    end
  end

endmodule
